memory_request_arbiter: RTL and testbench

- Sits directly downstream of the per-core vector load/store units and upstream of the shared memory port.
- Accepts one held `mem_req` per core and picks a winner round-robin. It returns a single-cycle grant to the winner and drives one registered request toward memory.
- Memory responses come back with a `core_id` tag. The block routes each one to the owning core's `mem_rsp` port.
- It tracks outstanding requests per core and masks any core that has reached its limit.

---
 rtl/memory_request_arbiter_pkg.sv | 33 +++
 rtl/memory_request_arbiter_rr_arbiter.sv | 32 +++
 rtl/memory_request_arbiter.sv | 128 ++++++++++++
 tb/tb_memory_request_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/memory_request_arbiter_pkg.sv
// Shared vector-unit types: the memory request record, request encodings
// and sizing constants used by the load/store path and the memory arbiter.
package memory_request_arbiter_pkg;

  localparam int VECTOR_REG_DEPTH      = 64;
  localparam int REQUEST_COUNTER_WIDTH = $clog2(VECTOR_REG_DEPTH + 1);
  // Three bits so that out-of-range tags from memory stay visible.
  localparam int CORE_ID_WIDTH         = 3;
  localparam int ACCESS_ID_WIDTH       = 6;
  localparam int ADDR_WIDTH            = 32;
  localparam int DATA_WIDTH            = 32;

  typedef enum logic [0:0] {
    READ_REQ  = 1'b0,
    WRITE_REQ = 1'b1
  } cntrl_req_t;

  typedef struct packed {
    logic                       vld;
    cntrl_req_t                 cntrl;
    logic [CORE_ID_WIDTH-1:0]   core_id;
    logic [ACCESS_ID_WIDTH-1:0] access_id;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [DATA_WIDTH-1:0]      data;
  } request_t;

  // True when a response tag names a core that actually exists.
  function automatic logic core_id_in_range(input logic [CORE_ID_WIDTH-1:0] id,
                                            input int num_cores);
    return (int'({1'b0, id}) < num_cores);
  endfunction

endpackage

// File: rtl/memory_request_arbiter_rr_arbiter.sv
// Combinational rotating-priority arbiter: the scan starts at rr_ptr and
// the first active request found wins. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int IDX_WIDTH = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  output logic [NUM_CORES-1:0] grant,
  output logic [IDX_WIDTH-1:0] winner,
  output logic                 any_grant
);

  // Scan rr_ptr, rr_ptr+1, ... modulo NUM_CORES and latch the first requester.
  always_comb begin
    logic [IDX_WIDTH-1:0] idx_v;
    logic                 hit_v;
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx_v     = '0;
    hit_v     = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx_v        = IDX_WIDTH'((int'(rr_ptr) + k) % NUM_CORES);
      hit_v        = ~any_grant & req[idx_v];
      grant[idx_v] = grant[idx_v] | hit_v;
      winner       = hit_v ? idx_v : winner;
      any_grant    = any_grant | hit_v;
    end
  end

endmodule

// File: rtl/memory_request_arbiter.sv
// Round-robin arbiter between per-core vector load/store units and the shared
// memory port. Registers one request toward memory, routes tagged responses
// back to their cores and limits the requests each core has in flight.
module memory_request_arbiter
  import memory_request_arbiter_pkg::*;
#(
  parameter int NUM_CORES       = 4,
  parameter int MAX_OUTSTANDING = VECTOR_REG_DEPTH,
  parameter int OUTST_WIDTH     = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  request_t             core_req [NUM_CORES],
  output logic [NUM_CORES-1:0] core_grant,
  output request_t             core_rsp [NUM_CORES],
  output request_t             mem_req,
  input  logic                 mem_req_grant,
  input  request_t             mem_rsp,
  output logic                 rsp_err
);

  localparam int IDX_WIDTH = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [IDX_WIDTH-1:0]   LAST_IDX    = IDX_WIDTH'(NUM_CORES - 1);
  localparam logic [OUTST_WIDTH-1:0] OUTST_LIMIT = OUTST_WIDTH'(MAX_OUTSTANDING);

  request_t               mem_req_r;
  request_t               core_rsp_r  [NUM_CORES];
  logic [OUTST_WIDTH-1:0] outst_r     [NUM_CORES];
  logic [OUTST_WIDTH-1:0] outst_nxt_s [NUM_CORES];
  logic [IDX_WIDTH-1:0]   rr_ptr_r;
  logic                   rsp_err_r;

  logic [NUM_CORES-1:0]   elig_s;
  logic [NUM_CORES-1:0]   arb_req_s;
  logic [NUM_CORES-1:0]   grant_s;
  logic [NUM_CORES-1:0]   rsp_hit_s;
  logic [IDX_WIDTH-1:0]   winner_s;
  logic [IDX_WIDTH-1:0]   next_ptr_s;
  logic                   any_s;
  logic                   slot_free_s;
  logic                   bad_tag_s;
  request_t               win_req_s;

  // The output slot can take a new request when empty or being drained now.
  assign slot_free_s = ~mem_req_r.vld | mem_req_grant;
  // Nothing is granted while in reset or while the slot is occupied.
  assign arb_req_s   = (slot_free_s & ~reset) ? elig_s : '0;
  assign bad_tag_s   = mem_rsp.vld & ~core_id_in_range(mem_rsp.core_id, NUM_CORES);
  assign next_ptr_s  = (winner_s == LAST_IDX) ? '0 : winner_s + IDX_WIDTH'(1);

  rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr_arbiter (
    .req       (arb_req_s),
    .rr_ptr    (rr_ptr_r),
    .grant     (grant_s),
    .winner    (winner_s),
    .any_grant (any_s)
  );

  // Winning request with its tag replaced by the true source core index.
  always_comb begin
    win_req_s         = core_req[winner_s];
    win_req_s.core_id = CORE_ID_WIDTH'(winner_s);
  end

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    assign elig_s[c]    = core_req[c].vld & (outst_r[c] < OUTST_LIMIT);
    assign rsp_hit_s[c] = mem_rsp.vld & (mem_rsp.core_id == CORE_ID_WIDTH'(c));
    assign core_rsp[c]  = core_rsp_r[c];

    // Outstanding count: +1 on grant, -1 on response (floor at 0), both cancel.
    always_comb begin
      case ({grant_s[c], rsp_hit_s[c]})
        2'b10: outst_nxt_s[c] = outst_r[c] + OUTST_WIDTH'(1);
        2'b01: begin
          if (outst_r[c] != '0) begin
            outst_nxt_s[c] = outst_r[c] - OUTST_WIDTH'(1);
          end else begin
            outst_nxt_s[c] = outst_r[c];
          end
        end
        default: outst_nxt_s[c] = outst_r[c];
      endcase
    end

    // Per-core counter and one-cycle response pulse registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        outst_r[c]    <= '0;
        core_rsp_r[c] <= '0;
      end else begin
        outst_r[c]    <= outst_nxt_s[c];
        core_rsp_r[c] <= rsp_hit_s[c] ? mem_rsp : '0;
      end
    end
  end

  // Output slot and round-robin pointer: load winner, drain when idle, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_r <= '0;
      rr_ptr_r  <= '0;
    end else if (slot_free_s) begin
      if (any_s) begin
        mem_req_r <= win_req_s;
        rr_ptr_r  <= next_ptr_s;
      end else begin
        mem_req_r.vld <= 1'b0;
      end
    end
  end

  // Sticky flag for responses tagged with a core that does not exist.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_err_r <= 1'b0;
    end else if (bad_tag_s) begin
      rsp_err_r <= 1'b1;
    end
  end

  assign core_grant = grant_s;
  assign mem_req    = mem_req_r;
  assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_memory_request_arbiter.sv
// Directed bench for memory_request_arbiter: a vector table applied one per
// cycle, followed by a hand-written back-to-back rotation sequence.
module tb_memory_request_arbiter;
  import memory_request_arbiter_pkg::*;

  localparam int NC   = 4;
  localparam int MAXO = 4;

  logic           clk = 1'b0;
  logic           reset;
  request_t       core_req [NC];
  logic [NC-1:0]  core_grant;
  request_t       core_rsp [NC];
  request_t       mem_req;
  logic           mem_req_grant;
  request_t       mem_rsp;
  logic           rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  memory_request_arbiter #(
    .NUM_CORES       (NC),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .core_req      (core_req),
    .core_grant    (core_grant),
    .core_rsp      (core_rsp),
    .mem_req       (mem_req),
    .mem_req_grant (mem_req_grant),
    .mem_rsp       (mem_rsp),
    .rsp_err       (rsp_err)
  );

  // One cycle: inputs applied, then grant (same cycle) and registered state
  // (result of the previous edge) compared.
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       mg;
    logic       rv;
    logic [2:0] rid;
    logic [3:0] eg;
    logic       emv;
    logic [2:0] emid;
    logic [3:0] ersp;
    logic       eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic mg,
                              input logic rv, input logic [2:0] rid, input logic [3:0] eg,
                              input logic emv, input logic [2:0] emid,
                              input logic [3:0] ersp, input logic eerr);
    vec_t v;
    v.rst = rst; v.req = req; v.mg = mg; v.rv = rv; v.rid = rid;
    v.eg = eg; v.emv = emv; v.emid = emid; v.ersp = ersp; v.eerr = eerr;
    return v;
  endfunction

  function automatic logic [31:0] core_addr(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0000_0100;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic mg, input logic rv,
                       input logic [2:0] rid);
    for (int i = 0; i < NC; i++) begin
      core_req[i].vld       = req[i];
      core_req[i].cntrl     = (i == 1) ? WRITE_REQ : READ_REQ;
      core_req[i].core_id   = 3'd5;
      core_req[i].access_id = 6'(10 + i);
      core_req[i].addr      = core_addr(i);
      core_req[i].data      = 32'hD000_0000 + 32'(i);
    end
    mem_req_grant     = mg;
    mem_rsp.vld       = rv;
    mem_rsp.cntrl     = READ_REQ;
    mem_rsp.core_id   = rid;
    mem_rsp.access_id = 6'd40 + 6'(rid);
    mem_rsp.addr      = 32'hA000_0000 + 32'(rid);
    mem_rsp.data      = 32'h5555_0000 + 32'(rid);
  endtask

  initial begin
    logic [3:0] exp_g;
    int         prev_w;
    int         w;

    reset = 1'b1;
    drive(4'b0000, 1'b0, 1'b0, 3'd0);

    //              rst  req      mg   rv   rid   grant    mv   mid   rsp      err
    // reset with every core requesting
    vecs.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0));
    vecs.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0));
    vecs.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b0, 3'd0, 4'b0001, 1'b0, 3'd0, 4'b0000, 1'b0));
    // cores 0 and 2 alternate
    vecs.push_back(mk(1'b0, 4'b0101, 1'b1, 1'b0, 3'd0, 4'b0100, 1'b1, 3'd0, 4'b0000, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0101, 1'b1, 1'b0, 3'd0, 4'b0001, 1'b1, 3'd2, 4'b0000, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0101, 1'b1, 1'b0, 3'd0, 4'b0100, 1'b1, 3'd0, 4'b0000, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0101, 1'b1, 1'b0, 3'd0, 4'b0001, 1'b1, 3'd2, 4'b0000, 1'b0));
    // idle drain, then backpressure on core 1
    vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 3'd0, 4'b0000, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0010, 1'b0, 1'b0, 3'd0, 4'b0010, 1'b0, 3'd0, 4'b0000, 1'b0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1'b0, 4'b0011, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b1, 3'd1, 4'b0000, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0011, 1'b1, 1'b0, 3'd0, 4'b0001, 1'b1, 3'd1, 4'b0000, 1'b0));
    // core 3 fills its outstanding budget (core 0 is also full now)
    vecs.push_back(mk(1'b0, 4'b1000, 1'b1, 1'b0, 3'd0, 4'b1000, 1'b1, 3'd0, 4'b0000, 1'b0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1'b0, 4'b1000, 1'b1, 1'b0, 3'd0, 4'b1000, 1'b1, 3'd3, 4'b0000, 1'b0));
    vecs.push_back(mk(1'b0, 4'b1001, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 3'd3, 4'b0000, 1'b0));
    vecs.push_back(mk(1'b0, 4'b1001, 1'b1, 1'b1, 3'd3, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0));
    vecs.push_back(mk(1'b0, 4'b1001, 1'b1, 1'b0, 3'd0, 4'b1000, 1'b0, 3'd0, 4'b1000, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 3'd3, 4'b0000, 1'b0));
    // grant and response for core 1 in the same cycle, then fill core 1
    vecs.push_back(mk(1'b0, 4'b0010, 1'b1, 1'b1, 3'd1, 4'b0010, 1'b0, 3'd0, 4'b0000, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0010, 1'b1, 1'b0, 3'd0, 4'b0010, 1'b1, 3'd1, 4'b0010, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0010, 1'b1, 1'b0, 3'd0, 4'b0010, 1'b1, 3'd1, 4'b0000, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0010, 1'b1, 1'b0, 3'd0, 4'b0010, 1'b1, 3'd1, 4'b0000, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0010, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 3'd1, 4'b0000, 1'b0));
    // bad tags set the sticky error; counters untouched
    vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 3'd7, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 3'd4, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b1));
    vecs.push_back(mk(1'b0, 4'b0100, 1'b1, 1'b0, 3'd0, 4'b0100, 1'b0, 3'd0, 4'b0000, 1'b1));
    // reset mid-flight, then a late response must not underflow core 2
    vecs.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 3'd2, 4'b0000, 1'b1));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 3'd2, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0));
    vecs.push_back(mk(1'b0, 4'b0100, 1'b1, 1'b0, 3'd0, 4'b0100, 1'b0, 3'd0, 4'b0100, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      drive(vecs[i].req, vecs[i].mg, vecs[i].rv, vecs[i].rid);
      #1;
      chk($sformatf("v%0d core_grant", i), 64'(core_grant), 64'(vecs[i].eg));
      chk($sformatf("v%0d mem_req.vld", i), 64'(mem_req.vld), 64'(vecs[i].emv));
      if (vecs[i].emv) begin
        chk($sformatf("v%0d mem_req.core_id", i), 64'(mem_req.core_id), 64'(vecs[i].emid));
        chk($sformatf("v%0d mem_req.addr", i), 64'(mem_req.addr),
            64'(core_addr(int'(vecs[i].emid))));
        chk($sformatf("v%0d mem_req.access_id", i), 64'(mem_req.access_id),
            64'(10 + int'(vecs[i].emid)));
      end
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("v%0d core_rsp[%0d].vld", i, c), 64'(core_rsp[c].vld),
            64'(vecs[i].ersp[c]));
        if (vecs[i].ersp[c]) begin
          chk($sformatf("v%0d core_rsp[%0d].addr", i, c), 64'(core_rsp[c].addr),
              64'(32'hA000_0000 + 32'(c)));
          chk($sformatf("v%0d core_rsp[%0d].access_id", i, c),
              64'(core_rsp[c].access_id), 64'(40 + c));
        end
      end
      chk($sformatf("v%0d rsp_err", i), 64'(rsp_err), 64'(vecs[i].eerr));
    end

    // Back-to-back with all cores requesting: pointer is at 3 after the table,
    // so winners rotate 3,0,1,2,... and mem_req follows one cycle later.
    prev_w = 2;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      reset = 1'b0;
      drive(4'b1111, 1'b1, 1'b0, 3'd0);
      #1;
      w     = (3 + k) % NC;
      exp_g = 4'b0001 << w;
      chk($sformatf("b2b%0d core_grant", k), 64'(core_grant), 64'(exp_g));
      chk($sformatf("b2b%0d mem_req.vld", k), 64'(mem_req.vld), 64'(1'b1));
      chk($sformatf("b2b%0d mem_req.core_id", k), 64'(mem_req.core_id), 64'(prev_w));
      chk($sformatf("b2b%0d mem_req.cntrl", k), 64'(mem_req.cntrl),
          64'((prev_w == 1) ? WRITE_REQ : READ_REQ));
      chk($sformatf("b2b%0d mem_req.data", k), 64'(mem_req.data),
          64'(32'hD000_0000 + 32'(prev_w)));
      prev_w = w;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
